// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the instruction memory and
// registers each fetched word (or a fault marker) into the IF/ID slot.
module fetch_stage #(
  parameter int unsigned    N          = 64,
  parameter logic [N-1:0]   RESET_PC   = '0,
  parameter int unsigned    IMEM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_instr,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         id_ready,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [N-1:0] id_pc,
  output logic [N-1:0] id_pc_plus4,
  output logic         id_fault,
  output logic [1:0]   id_fault_cause
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [N:0]  LIMIT = (N+1)'(IMEM_WORDS) << 2;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [N-1:0] idpc_q, idpc_d;
  logic [N-1:0] plus4_q, plus4_d;
  logic         fault_q, fault_d;
  logic [1:0]   cause_q, cause_d;

  logic         advance;
  logic         misaligned;
  logic         out_of_range;
  logic [1:0]   cause;
  logic [N-1:0] pc_plus4;

  assign advance      = !valid_q || id_ready;
  assign pc_plus4     = pc_q + N'(4);
  assign misaligned   = pc_q[1:0] != 2'b00;
  assign out_of_range = {1'b0, pc_q} >= LIMIT;
  assign cause        = misaligned   ? 2'b01 :
                        out_of_range ? 2'b10 : 2'b00;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    plus4_d = plus4_q;
    fault_d = fault_q;
    cause_d = cause_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (advance) begin
            idpc_d  = pc_q;
            plus4_d = pc_plus4;
            valid_d = 1'b1;
            if (cause != 2'b00) begin
              // pc parks on the faulting address until redirected
              instr_d = NOP;
              fault_d = 1'b1;
              cause_d = cause;
              state_d = HOLD;
            end else begin
              instr_d = imem_instr;
              fault_d = 1'b0;
              cause_d = 2'b00;
              pc_d    = pc_plus4;
            end
          end
        end
        HOLD: begin
          if (valid_q && id_ready) valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      idpc_q  <= '0;
      plus4_q <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      plus4_q <= plus4_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign imem_addr      = pc_q;
  assign id_valid       = valid_q;
  assign id_instr       = instr_q;
  assign id_pc          = idpc_q;
  assign id_pc_plus4    = plus4_q;
  assign id_fault       = fault_q;
  assign id_fault_cause = cause_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV64I datapath: owns the program counter, drives the combinational instruction memory address, and registers the returned 32-bit instruction into the IF/ID boundary with a valid/ready handshake toward decode. Supports stall (decode back-pressure), redirect/flush from branch/jump resolution, and fetch-fault detection (misaligned or out-of-range PC). It sits directly upstream of the instruction memory and directly feeds the decode stage.

## Interface
- N, 64, XLEN; width of PC and all addresses
- RESET_PC, 0, PC value loaded on reset
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal fetch range is [0, IMEM_WORDS*4)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  N  byte address to instruction memory; equals pc register, combinational
- imem_instr  in  32  instruction returned combinationally for imem_addr
- redirect_valid  in  1  taken branch/jump; flush and load new PC
- redirect_pc  in  N  redirect target (byte address)
- id_ready  in  1  decode accepts the current id_* entry
- id_valid  out  1  id_* entry is valid
- id_instr  out  32  fetched instruction
- id_pc  out  N  PC of id_instr
- id_pc_plus4  out  N  id_pc + 4, modulo 2^N
- id_fault  out  1  entry is a fetch fault, not a real instruction
- id_fault_cause  out  2  01 misaligned, 10 out of range, 00 no fault

## Operation
- State: pc register, IF/ID output register, FSM {FETCH, HOLD}.
- advance = !id_valid || id_ready.
- fault detection on current pc: misaligned if pc[1:0] != 0; else out of range if pc >= IMEM_WORDS*4; misaligned takes priority.
- Priority per cycle: rst > redirect_valid > advance > hold.
- redirect_valid=1 (any state): id_valid <= 0 (flush), pc <= redirect_pc, state <= FETCH; imem_instr that cycle discarded. Redirect target is not checked until it is fetched.
- FETCH, advance, no fault: id_instr <= imem_instr, id_pc <= pc, id_pc_plus4 <= pc+4, id_fault <= 0, cause <= 00, id_valid <= 1, pc <= pc+4.
- FETCH, advance, fault: id_instr <= 0x00000013 (NOP), id_pc <= pc, id_pc_plus4 <= pc+4, id_fault <= 1, cause per rule, id_valid <= 1, pc unchanged, state <= HOLD.
- FETCH, !advance: all registers hold (stall).
- HOLD: no fetch. If id_ready while id_valid, id_valid <= 0. Remains in HOLD until redirect_valid.
- pc+4 wraps modulo 2^N; pc = 2^N-4 fetches give id_pc_plus4 = 0 and pc -> 0.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0x00000013, id_pc=0, id_pc_plus4=0, id_fault=0, id_fault_cause=00; imem_addr=RESET_PC.
- First entry valid on the first rising edge after rst deasserts.
- Latency: imem_addr=X in cycle k with advance -> id_pc=X, id_valid=1 in cycle k+1.
- Throughput: one instruction per cycle while id_ready=1.
- Handshake: entry transfers on edge where id_valid && id_ready; while id_valid && !id_ready, all id_* stable.
- Redirect and id_ready in same cycle: redirect wins; current entry counts as consumed, nothing new loaded; first target entry appears one cycle later (1-cycle bubble).
- Redirect in same cycle as a fault fetch: redirect wins, no fault reported.
- rst asserted mid-stall or in HOLD: outputs return to reset values immediately, without a clock edge.

## Test plan
- Reset release, RESET_PC=0, id_ready=1, memory 0x00500093,0x00A00113,... -> id_pc 0,4,8 on consecutive cycles, id_instr matches, id_pc_plus4 = id_pc+4.
- Stall: id_ready=0 for 3 cycles at id_pc=8 -> id_* stable, imem_addr=0xC held; release -> id_pc=0xC next cycle, no skip or duplicate.
- Redirect to 0x100 while id_pc=0x10 valid -> next cycle id_valid=0, imem_addr=0x100; following cycle id_pc=0x100 valid.
- Redirect to 0x102 -> fault entry id_fault=1, cause=01, id_instr=0x00000013, state HOLD, id_valid=0 after accept; redirect to 0x40 resumes at 0x40.
- Sequential fetch reaching 0xFFC -> 0xFFC valid, then fault at 0x1000 with cause=10; redirect with id_ready=1 same cycle -> redirect wins.
- Assert rst asynchronously mid-stall and in HOLD -> all outputs reset values before next edge; RESET_PC=0x200 build starts fetching at 0x200.
